// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the DMemory two-requester arbiter.
//   arb_state_t : arbiter FSM states (IDLE, WAIT, ERR)
//   req_id_t    : requester identifier (0 = core data port, 1 = secondary)
//   ERR_RDATA   : read data returned with every error response
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } arb_state_t;

    typedef logic req_id_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/dmem_arb_pick.sv
// ---------------------------------------------------------------------------
// dmem_arb_pick
// Combinational winner selection between the two DMemory requesters.
// Configuration macro: DMEM_ARB_ROUND_ROBIN_EN
//   defined   : on simultaneous requests the requester named by ptr_i wins
//   undefined : fixed priority, requester 0 always wins (no ptr_i port)
// Ports:
//   ptr_i   in  1  round-robin pointer (only with DMEM_ARB_ROUND_ROBIN_EN)
//   req_i   in  2  request bit per requester
//   win_o   out 1  id of the winning requester (0 when nothing requests)
//   valid_o out 1  at least one request is present
// ---------------------------------------------------------------------------
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    input  logic       ptr_i,
`endif
    input  logic [1:0] req_i,
    output req_id_t    win_o,
    output logic       valid_o
);

    assign valid_o = |req_i;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    // A lone request always wins; the pointer only breaks ties.
    assign win_o = (req_i == 2'b11) ? ptr_i : req_i[1];
`else
    // Requester 1 only wins when requester 0 is silent.
    assign win_o = req_i[1] & ~req_i[0];
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single DMemory port between the core data port (requester 0)
// and a secondary master (requester 1). One transaction is outstanding at a
// time; each address is range-checked against the DMemory window and every
// read is guaranteed a response through a wait timeout.
// Configuration macro: DMEM_ARB_ROUND_ROBIN_EN (round-robin instead of
// fixed priority for requester 0).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_i/we_i [1:0]         request and write flag per requester
//   addr0_i/addr1_i [31:0]   byte address per requester
//   wdata0_i/wdata1_i [31:0] write data per requester
//   wmask0_i/wmask1_i [3:0]  byte write mask per requester
//   gnt_o [1:0]              one-cycle grant pulse
//   rvalid_o [1:0]           one-cycle read-data-valid pulse
//   rdata_o [31:0]           read data, qualified by rvalid_o
//   err_o                    out-of-range or timeout pulse
//   m_addr_o/m_wdata_o/m_wmask_o/m_we_o/m_re_o  DMemory request side
//   m_rvalid_i/m_rdata_i     DMemory read response
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] BASE    = 32'h9000_0000,
    parameter logic [31:0] SIZE    = 32'h0000_0800,
    parameter int          TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [31:0] addr0_i,
    input  logic [31:0] addr1_i,
    input  logic [31:0] wdata0_i,
    input  logic [31:0] wdata1_i,
    input  logic [3:0]  wmask0_i,
    input  logic [3:0]  wmask1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    output logic [3:0]  m_wmask_o,
    output logic        m_we_o,
    output logic        m_re_o,
    input  logic        m_rvalid_i,
    input  logic [31:0] m_rdata_i
);

    localparam logic [4:0] LAST_WAIT = 5'(TIMEOUT - 1);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    req_id_t     r_id;
    logic [4:0]  r_cnt;

    req_id_t     w_win;
    logic        w_valid;
    logic [31:0] w_addr;
    logic        w_we;
    logic        w_in_range;
    logic        w_grant;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic r_ptr;

    dmem_arb_pick u_pick (
        .ptr_i   (r_ptr),
        .req_i   (req_i),
        .win_o   (w_win),
        .valid_o (w_valid)
    );

    // After each grant the other requester becomes favoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= ~w_win;
        end
    end
`else
    dmem_arb_pick u_pick (
        .req_i   (req_i),
        .win_o   (w_win),
        .valid_o (w_valid)
    );
`endif

    assign w_addr = w_win ? addr1_i : addr0_i;
    assign w_we   = we_i[w_win];

    // 33-bit compare so a window ending at the top of memory cannot wrap.
    assign w_in_range = ({1'b0, w_addr} >= {1'b0, BASE}) &&
                        ({1'b0, w_addr} <  ({1'b0, BASE} + {1'b0, SIZE}));

    assign w_grant = !rst && (r_state == IDLE) && w_valid;

    // The counter is held at zero outside WAIT, so it starts from zero on
    // every entry into WAIT and then saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_id    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_id <= w_win;
            end
            if (r_state != WAIT) begin
                r_cnt <= '0;
            end else if (r_cnt != 5'h1F) begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    // Outputs are gated by rst so an abandoned transaction emits nothing.
    always_comb begin
        w_state_nxt = r_state;
        gnt_o       = 2'b00;
        rvalid_o    = 2'b00;
        rdata_o     = '0;
        err_o       = 1'b0;
        m_addr_o    = '0;
        m_wdata_o   = '0;
        m_wmask_o   = '0;
        m_we_o      = 1'b0;
        m_re_o      = 1'b0;
        if (!rst) begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        gnt_o     = w_win ? 2'b10 : 2'b01;
                        m_addr_o  = w_addr;
                        m_wdata_o = w_win ? wdata1_i : wdata0_i;
                        m_wmask_o = w_win ? wmask1_i : wmask0_i;
                        if (w_we) begin
                            if (w_in_range) begin
                                m_we_o = 1'b1;
                            end else begin
                                err_o = 1'b1;
                            end
                        end else if (w_in_range) begin
                            m_re_o      = 1'b1;
                            w_state_nxt = WAIT;
                        end else begin
                            w_state_nxt = ERR;
                        end
                    end
                end
                WAIT: begin
                    if (m_rvalid_i) begin
                        rvalid_o    = r_id ? 2'b10 : 2'b01;
                        rdata_o     = m_rdata_i;
                        w_state_nxt = IDLE;
                    end else if (r_cnt == LAST_WAIT) begin
                        rvalid_o    = r_id ? 2'b10 : 2'b01;
                        rdata_o     = ERR_RDATA;
                        err_o       = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
                ERR: begin
                    rvalid_o    = r_id ? 2'b10 : 2'b01;
                    rdata_o     = ERR_RDATA;
                    err_o       = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
